// File: rtl/shift_pkg.sv
// Shared types and defaults for the multi-cycle shifter.
// Optional rotate mode is gated by SHIFT_ROTATE_EN in the consumers of this package.
package shift_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_STEP  = 1;

    typedef enum logic [1:0] {
        SHM_SLL = 2'b00,
        SHM_SRL = 2'b01,
        SHM_SRA = 2'b10,
        SHM_ROL = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: shifts by k (1..STEP) and reports the boundary bit.
// Rotate-left support exists only when SHIFT_ROTATE_EN is defined.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned STEP  = DEF_STEP
) (
    input  logic [WIDTH-1:0]             data_i,
    input  logic [$clog2(STEP+1)-1:0]    k_i,
    input  shift_mode_e                  mode_i,
    input  logic                         sign_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         carry_o
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic [WIDTH-1:0] fill;

    // hi_idx: last bit to leave on a left shift; lo_idx: last bit to leave on a right shift
    assign hi_idx = IDX_W'(WIDTH - 32'(k_i));
    assign lo_idx = IDX_W'(32'(k_i) - 32'd1);
    assign fill   = sign_i ? ~({WIDTH{1'b1}} >> k_i) : '0;

    always_comb begin
        data_o  = data_i << k_i;
        carry_o = data_i[hi_idx];
        case (mode_i)
            SHM_SRL: begin
                data_o  = data_i >> k_i;
                carry_o = data_i[lo_idx];
            end
            SHM_SRA: begin
                data_o  = (data_i >> k_i) | fill;
                carry_o = data_i[lo_idx];
            end
`ifdef SHIFT_ROTATE_EN
            SHM_ROL: begin
                data_o  = (data_i << k_i) | (data_i >> hi_idx);
                carry_o = data_i[hi_idx];
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter with valid/ready on both sides, shifting STEP bits per cycle.
// SHIFT_ROTATE_EN enables mode 11 as rotate-left; otherwise mode 11 behaves as SLL.
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned STEP    = DEF_STEP,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_carry,
    output logic               busy
);

    localparam int unsigned K_W = $clog2(STEP + 1);

    shift_state_e       state_q, state_d;
    shift_mode_e        mode_q, mode_d, mode_in;
    logic [WIDTH-1:0]   data_q, data_d, step_data;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic               carry_q, carry_d, step_carry;
    logic               sign_q, sign_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [K_W-1:0]     k;
    logic               accept;

    assign accept = in_valid && in_ready_q;
    assign k      = (32'(rem_q) >= STEP) ? K_W'(STEP) : K_W'(rem_q);

`ifdef SHIFT_ROTATE_EN
    assign mode_in = shift_mode_e'(in_mode);
`else
    assign mode_in = (in_mode == SHM_ROL) ? SHM_SLL : shift_mode_e'(in_mode);
`endif

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data_i  (data_q),
        .k_i     (k),
        .mode_i  (mode_q),
        .sign_i  (sign_q),
        .data_o  (step_data),
        .carry_o (step_carry)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= SHM_SLL;
            data_q      <= '0;
            rem_q       <= '0;
            carry_q     <= 1'b0;
            sign_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            data_q      <= data_d;
            rem_q       <= rem_d;
            carry_q     <= carry_d;
            sign_q      <= sign_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = (in_shamt == '0) ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (rem_q == SHAMT_W'(k)) state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Operand capture and per-cycle shift
    always_comb begin
        data_d  = data_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        carry_d = carry_q;
        sign_d  = sign_q;
        if (state_q == ST_IDLE && accept) begin
            data_d  = in_data;
            mode_d  = mode_in;
            rem_d   = in_shamt;
            carry_d = 1'b0;
            sign_d  = in_data[WIDTH-1];
        end else if (state_q == ST_SHIFT) begin
            data_d  = step_data;
            carry_d = step_carry;
            rem_d   = rem_q - SHAMT_W'(k);
        end
    end

    // Handshake/status outputs, registered from the next state
    always_comb begin
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = data_q;
    assign out_carry = carry_q;

endmodule
